// File: rtl/stage4_memory_bus_pkg.sv
// ============================================================================
// Module   : stage4_memory_bus_pkg
// Brief    : Shared encodings and lane helpers for the memory stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package stage4_memory_bus_pkg;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t MEM_SIZE_BYTE  = 2'd0;
  localparam mem_size_t MEM_SIZE_HALF  = 2'd1;
  localparam mem_size_t MEM_SIZE_WORD  = 2'd2;
  localparam mem_size_t MEM_SIZE_DWORD = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic int lane_bits(input int data_w);
    return (data_w == 64) ? 3 : 2;
  endfunction

  // A 32-bit bus has no dword lanes, so a dword request degrades to a word.
  function automatic mem_size_t eff_size(input mem_size_t sz, input int data_w);
    return (data_w == 32 && sz == MEM_SIZE_DWORD) ? MEM_SIZE_WORD : sz;
  endfunction

  function automatic logic [2:0] size_low_mask(input mem_size_t sz);
    case (sz)
      MEM_SIZE_BYTE: return 3'b000;
      MEM_SIZE_HALF: return 3'b001;
      MEM_SIZE_WORD: return 3'b011;
      default:       return 3'b111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage4_memory_bus_if.sv
// ============================================================================
// Module   : stage4_memory_bus_if
// Brief    : Single-outstanding req/ack data bus between memory stage and memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface stage4_memory_bus_if #(
  parameter int DATA_W = 32
);
  import stage4_memory_bus_pkg::*;

  localparam int LANES     = DATA_W / 8;
  localparam int LANE_BITS = lane_bits(DATA_W);

  logic                        req;
  logic                        we;
  logic [DATA_W-LANE_BITS-1:0] addr;
  logic [LANES-1:0]            be;
  logic [DATA_W-1:0]           wdata;
  logic [DATA_W-1:0]           rdata;
  logic                        ack;

  modport master (output req, we, addr, be, wdata, input  rdata, ack);
  modport slave  (input  req, we, addr, be, wdata, output rdata, ack);

endinterface

`default_nettype wire

// File: rtl/stage4_memory_bus_mem_lane_align.sv
// ============================================================================
// Module   : mem_lane_align
// Brief    : Byte enables, store replication and load lane extraction/extension.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_align
  import stage4_memory_bus_pkg::*;
#(
  parameter  int DATA_W    = 32,
  localparam int LANES     = DATA_W / 8,
  localparam int LANE_BITS = lane_bits(DATA_W)
) (
  input  mem_size_t              i_size,
  input  logic [LANE_BITS-1:0]   i_offset,
  input  logic                   i_signed,
  input  logic [DATA_W-1:0]      i_store_data,
  input  logic [DATA_W-1:0]      i_rdata,
  output logic [LANES-1:0]       o_be,
  output logic [DATA_W-1:0]      o_wdata,
  output logic [DATA_W-1:0]      o_load_val
);

  logic [LANES-1:0]     w_mask;
  logic [DATA_W-1:0]    w_keep;
  logic                 w_sign;
  logic [DATA_W-1:0]    w_shifted;
  logic [LANE_BITS+2:0] w_shamt;

  assign w_shamt   = {i_offset, 3'b000};
  assign w_shifted = i_rdata >> w_shamt;

  always_comb begin
    w_mask  = '1;
    w_keep  = '1;
    w_sign  = 1'b0;
    o_wdata = i_store_data;
    case (i_size)
      MEM_SIZE_BYTE: begin
        w_mask  = LANES'(1);
        w_keep  = DATA_W'(8'hFF);
        w_sign  = w_shifted[7];
        o_wdata = {LANES{i_store_data[7:0]}};
      end
      MEM_SIZE_HALF: begin
        w_mask  = LANES'(3);
        w_keep  = DATA_W'(16'hFFFF);
        w_sign  = w_shifted[15];
        o_wdata = {(LANES/2){i_store_data[15:0]}};
      end
      MEM_SIZE_WORD: begin
        w_mask  = LANES'(15);
        w_keep  = DATA_W'(32'hFFFF_FFFF);
        w_sign  = w_shifted[31];
        o_wdata = {(LANES/4){i_store_data[31:0]}};
      end
      default: ;
    endcase
  end

  assign o_be       = w_mask << i_offset;
  assign o_load_val = (w_shifted & w_keep) | ({DATA_W{i_signed & w_sign}} & ~w_keep);

endmodule

`default_nettype wire

// File: rtl/stage4_memory_bus.sv
// ============================================================================
// Module   : stage4_memory_bus
// Brief    : Memory stage with req/ack data bus, sized loads/stores, wait-state
//            stall. Optional macro MEM_MISALIGN_TRAP_EN adds misalign_o trap.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stage4_memory_bus
  import stage4_memory_bus_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int WB_REG_W  = 4,
  localparam int LANES     = DATA_W / 8,
  localparam int LANE_BITS = lane_bits(DATA_W)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_W-1:0]    alu_i,
  input  logic [DATA_W-1:0]    store_data_i,
  input  logic                 control_load_i,
  input  logic                 control_store_i,
  input  logic [1:0]           control_size_i,
  input  logic                 control_signed_i,
  input  logic                 control_take_branch_i,
  input  logic                 do_wb_i,
  input  logic [WB_REG_W-1:0]  wb_reg_i,
  output logic                 stall_o,
  output logic                 take_branch_o,
  output logic [DATA_W-3:0]    branch_pc_o,
  output logic                 do_wb_o,
  output logic [WB_REG_W-1:0]  wb_reg_o,
  output logic [DATA_W-1:0]    wb_val_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                 misalign_o,
`endif
  stage4_memory_bus_if.master  dbus
);

  logic [1:0]          r_state;
  logic [DATA_W-1:0]   r_alu;
  logic [DATA_W-1:0]   r_sdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_load;
  logic                r_store;
  mem_size_t           r_size;
  logic                r_signed;
  logic                r_branch;
  logic                r_do_wb;
  logic [WB_REG_W-1:0] r_wb_reg;
  logic                r_trap;

  logic                 w_access;
  logic                 w_mem_in;
  mem_size_t            w_size_in;
  logic                 w_trap_in;
  logic [LANE_BITS-1:0] w_low_mask;
  logic [LANE_BITS-1:0] w_offset;
  logic [LANES-1:0]     w_be;
  logic [DATA_W-1:0]    w_wdata;
  logic [DATA_W-1:0]    w_load_val;

  assign w_access  = (r_state == ST_ACCESS);
  assign w_mem_in  = control_load_i | control_store_i;
  assign w_size_in = eff_size(control_size_i, DATA_W);

`ifdef MEM_MISALIGN_TRAP_EN
  logic [2:0] w_in_mask;
  assign w_in_mask  = size_low_mask(w_size_in);
  assign w_trap_in  = w_mem_in & (|(alu_i[2:0] & w_in_mask));
  assign misalign_o = r_trap;
`else
  assign w_trap_in  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_alu    <= '0;
      r_sdata  <= '0;
      r_rdata  <= '0;
      r_load   <= 1'b0;
      r_store  <= 1'b0;
      r_size   <= MEM_SIZE_BYTE;
      r_signed <= 1'b0;
      r_branch <= 1'b0;
      r_do_wb  <= 1'b0;
      r_wb_reg <= '0;
      r_trap   <= 1'b0;
    end else if (w_access) begin
      r_trap <= 1'b0;
      if (dbus.ack) begin
        r_rdata <= dbus.rdata;
        r_state <= ST_DONE;
      end
    end else begin
      // IDLE and DONE both accept the next op from upstream.
      r_alu    <= alu_i;
      r_sdata  <= store_data_i;
      r_load   <= control_load_i;
      r_store  <= control_store_i & ~control_load_i;
      r_size   <= w_size_in;
      r_signed <= control_signed_i;
      r_branch <= control_take_branch_i;
      r_do_wb  <= do_wb_i;
      r_wb_reg <= wb_reg_i;
      r_trap   <= w_trap_in;
      r_state  <= (w_mem_in && !w_trap_in) ? ST_ACCESS : ST_IDLE;
    end
  end

  // Misaligned low bits are dropped so the access lands on its natural boundary.
  assign w_low_mask = LANE_BITS'(size_low_mask(r_size));
  assign w_offset   = r_alu[LANE_BITS-1:0] & ~w_low_mask;

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .i_size       (r_size),
    .i_offset     (w_offset),
    .i_signed     (r_signed),
    .i_store_data (r_sdata),
    .i_rdata      (r_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_val   (w_load_val)
  );

  assign stall_o       = w_access;
  assign take_branch_o = r_branch & ~w_access;
  assign branch_pc_o   = r_alu[DATA_W-1:2];
  assign do_wb_o       = r_do_wb & ~r_store & ~w_access & ~r_trap;
  assign wb_reg_o      = r_wb_reg;
  assign wb_val_o      = (r_state == ST_DONE && r_load) ? w_load_val : r_alu;

  assign dbus.req   = w_access;
  assign dbus.we    = w_access & r_store;
  assign dbus.addr  = r_alu[DATA_W-1:LANE_BITS];
  assign dbus.be    = w_access ? w_be : '0;
  assign dbus.wdata = w_wdata;

endmodule

`default_nettype wire

// File: tb/tb_stage4_memory_bus.sv
// ============================================================================
// Module   : tb_stage4_memory_bus
// Brief    : Directed plus randomized bench for stage4_memory_bus (DATA_W=32).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stage4_memory_bus;
  import stage4_memory_bus_pkg::*;

  localparam int DATA_W    = 32;
  localparam int WB_REG_W  = 4;
  localparam int LANES     = 4;
  localparam int LANE_BITS = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_W-1:0]   alu_i = '0, store_data_i = '0;
  logic                control_load_i = 0, control_store_i = 0;
  logic [1:0]          control_size_i = 0;
  logic                control_signed_i = 0, control_take_branch_i = 0, do_wb_i = 0;
  logic [WB_REG_W-1:0] wb_reg_i = '0;
  logic                stall_o, take_branch_o, do_wb_o;
  logic [DATA_W-3:0]   branch_pc_o;
  logic [WB_REG_W-1:0] wb_reg_o;
  logic [DATA_W-1:0]   wb_val_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                misalign_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stage4_memory_bus_if #(.DATA_W(DATA_W)) dbus ();

  stage4_memory_bus #(.DATA_W(DATA_W), .WB_REG_W(WB_REG_W)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .alu_i                 (alu_i),
    .store_data_i          (store_data_i),
    .control_load_i        (control_load_i),
    .control_store_i       (control_store_i),
    .control_size_i        (control_size_i),
    .control_signed_i      (control_signed_i),
    .control_take_branch_i (control_take_branch_i),
    .do_wb_i               (do_wb_i),
    .wb_reg_i              (wb_reg_i),
    .stall_o               (stall_o),
    .take_branch_o         (take_branch_o),
    .branch_pc_o           (branch_pc_o),
    .do_wb_o               (do_wb_o),
    .wb_reg_o              (wb_reg_o),
    .wb_val_o              (wb_val_o),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o            (misalign_o),
`endif
    .dbus                  (dbus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes, aligned lane offset, lane maps.
  function automatic int nbytes_of(input logic [1:0] sz);
    int n;
    n = 1 << sz;
    if (n > LANES) n = LANES;
    return n;
  endfunction

  function automatic int off_of(input logic [DATA_W-1:0] a, input logic [1:0] sz);
    int n;
    n = nbytes_of(sz);
    return ((a % LANES) / n) * n;
  endfunction

  function automatic logic [LANES-1:0] exp_be(input logic [DATA_W-1:0] a, input logic [1:0] sz);
    logic [LANES-1:0] be;
    be = '0;
    for (int i = 0; i < nbytes_of(sz); i++) be[off_of(a, sz) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] exp_wdata(input logic [DATA_W-1:0] sd, input logic [1:0] sz);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < LANES; i++) w[8*i +: 8] = sd[8*(i % nbytes_of(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] exp_load(input logic [DATA_W-1:0] a, input logic [1:0] sz,
                                                 input logic sgn, input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] v;
    int n, off;
    n = nbytes_of(sz);
    off = off_of(a, sz);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
    if (sgn && v[8*n-1])
      for (int i = n; i < LANES; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sgn,
                       input logic br, input logic dwb, input logic [WB_REG_W-1:0] rg,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd);
    control_load_i = ld;  control_store_i = st;  control_size_i = sz;
    control_signed_i = sgn;  control_take_branch_i = br;  do_wb_i = dwb;
    wb_reg_i = rg;  alu_i = alu;  store_data_i = sd;
  endtask

  // Presents one op in a non-stalled cycle and plays the bus slave for it.
  // Returns in the cycle after the op completes (DONE for memory ops).
  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic sgn,
                       input logic br, input logic dwb, input logic [WB_REG_W-1:0] rg,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                       input logic [DATA_W-1:0] rd, input int waits);
    logic mem, eff_st;
    mem    = ld | st;
    eff_st = st & ~ld;
    chk("stall_before_capture", stall_o, 0);
    drive(ld, st, sz, sgn, br, dwb, rg, alu, sd);
    step();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
`ifdef MEM_MISALIGN_TRAP_EN
    if (mem && (alu % nbytes_of(sz)) != 0) begin
      chk("trap_pulse", misalign_o, 1);
      chk("trap_no_req", dbus.req, 0);
      chk("trap_no_stall", stall_o, 0);
      chk("trap_no_wb", do_wb_o, 0);
      step();
      chk("trap_pulse_end", misalign_o, 0);
      chk("trap_still_no_req", dbus.req, 0);
      return;
    end
    chk("no_trap", misalign_o, 0);
`endif
    if (mem) begin
      chk("req", dbus.req, 1);
      chk("we", dbus.we, eff_st);
      chk("addr", dbus.addr, alu >> LANE_BITS);
      chk("be", dbus.be, exp_be(alu, sz));
      chk("wdata", dbus.wdata, exp_wdata(sd, sz));
      chk("stall_access", stall_o, 1);
      chk("wb_bubble", do_wb_o, 0);
      for (int w = 0; w < waits; w++) begin
        step();
        chk("req_hold", dbus.req, 1);
        chk("be_hold", dbus.be, exp_be(alu, sz));
        chk("stall_wait", stall_o, 1);
      end
      dbus.ack = 1'b1;
      dbus.rdata = rd;
      step();
      dbus.ack = 1'b0;
      dbus.rdata = $urandom;
      chk("req_drop", dbus.req, 0);
      chk("stall_done", stall_o, 0);
      chk("done_do_wb", do_wb_o, dwb & ~eff_st);
      chk("done_wb_reg", wb_reg_o, rg);
      chk("done_wb_val", wb_val_o, ld ? exp_load(alu, sz, sgn, rd) : alu);
    end else begin
      chk("alu_stall", stall_o, 0);
      chk("alu_req", dbus.req, 0);
      chk("alu_do_wb", do_wb_o, dwb);
      chk("alu_wb_reg", wb_reg_o, rg);
      chk("alu_wb_val", wb_val_o, alu);
      chk("alu_branch", take_branch_o, br);
      chk("alu_branch_pc", branch_pc_o, alu[DATA_W-1:2]);
    end
  endtask

  initial begin
    dbus.ack = 1'b0;
    dbus.rdata = '0;
    step();
    step();
    chk("rst_stall", stall_o, 0);
    chk("rst_take_branch", take_branch_o, 0);
    chk("rst_branch_pc", branch_pc_o, 0);
    chk("rst_do_wb", do_wb_o, 0);
    chk("rst_wb_reg", wb_reg_o, 0);
    chk("rst_wb_val", wb_val_o, 0);
    chk("rst_req", dbus.req, 0);
    chk("rst_we", dbus.we, 0);
    chk("rst_be", dbus.be, 0);
    rst_n = 1'b1;
    step();

    // ALU writeback
    do_op(0, 0, MEM_SIZE_WORD, 0, 0, 1, 4'd5, 32'h1234, '0, '0, 0);
    chk("alu_const_val", wb_val_o, 32'h0000_1234);

    // signed byte load with three wait states
    do_op(1, 0, MEM_SIZE_BYTE, 1, 0, 1, 4'd3, 32'h103, '0, 32'h80FF_0000, 3);
    chk("sbyte_const_val", wb_val_o, 32'hFFFF_FF80);

    // half store
    do_op(0, 1, MEM_SIZE_HALF, 0, 0, 1, 4'd2, 32'h202, 32'h0000_BEEF, '0, 1);
    chk("hstore_no_wb", do_wb_o, 0);

    // back-to-back zero-wait loads, then an unsigned half load
    do_op(1, 0, MEM_SIZE_WORD, 0, 0, 1, 4'd7, 32'h400, '0, 32'hCAFE_F00D, 0);
    do_op(1, 0, MEM_SIZE_WORD, 0, 0, 1, 4'd8, 32'h404, '0, 32'h1357_9BDF, 0);
    do_op(1, 0, MEM_SIZE_HALF, 0, 0, 1, 4'd9, 32'h406, '0, 32'h8001_0000, 0);
    chk("uhalf_const_val", wb_val_o, 32'h0000_8001);

    // load and store together: load wins
    do_op(1, 1, MEM_SIZE_BYTE, 0, 0, 1, 4'd1, 32'h11, 32'hFF, 32'h0000_A500, 0);

    // misaligned word load
    do_op(1, 0, MEM_SIZE_WORD, 0, 0, 1, 4'd4, 32'h101, '0, 32'h0102_0304, 0);
`ifndef MEM_MISALIGN_TRAP_EN
    chk("misalign_masked_val", wb_val_o, 32'h0102_0304);
`endif

    // taken branch on a non-memory op
    do_op(0, 0, MEM_SIZE_BYTE, 0, 1, 0, 4'd0, 32'h0000_8004, '0, '0, 0);
    step();

    // reset during an access, then a stray ack
    drive(1, 0, MEM_SIZE_WORD, 0, 0, 1, 4'd6, 32'h300, '0);
    step();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
    chk("mid_req", dbus.req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", dbus.req, 0);
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_do_wb", do_wb_o, 0);
    chk("mid_rst_wb_val", wb_val_o, 0);
    chk("mid_rst_wb_reg", wb_reg_o, 0);
    chk("mid_rst_be", dbus.be, 0);
    step();
    rst_n = 1'b1;
    dbus.ack = 1'b1;
    dbus.rdata = 32'hDEAD_BEEF;
    step();
    dbus.ack = 1'b0;
    chk("late_ack_req", dbus.req, 0);
    chk("late_ack_stall", stall_o, 0);
    chk("late_ack_do_wb", do_wb_o, 0);
    chk("late_ack_wb_val", wb_val_o, 0);

    // randomized mix
    for (int k = 0; k < 80; k++) begin
      int kind;
      logic [DATA_W-1:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom & 32'h0000_FFFF;
      do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), kind == 0 ? 1'($urandom_range(0, 1)) : 1'b0,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, $urandom,
            $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
